// File: rtl/tx_serializer.sv
// -----------------------------------------------------------------------------
// tx_serializer
//   Asynchronous-serial (UART-style) frame transmitter. One serial bit period
//   per rising edge of BaudOut. A single-entry holding buffer accepts the next
//   word while the current frame is on the line. This allows back-to-back
//   frames with no idle gap.
//
//   Frame: start(0), DATA_WIDTH data bits (LSB or MSB first), optional
//   odd/even parity bit, then 1 or 2 stop bits (1). The per-frame settings are
//   latched when the frame starts, so later input changes wait for the next
//   frame.
//
//   Handshake: a word is accepted on a rising edge where SendValid and
//   SendReady are both high. SendReady is high exactly when the holding
//   buffer is empty. SendValid may be held high for any number of cycles.
//
// Ports
//   BaudOut      in   bit clock
//   ResetN       in   asynchronous active-low reset
//   DataIn       in   word to transmit (DATA_WIDTH bits)
//   SendValid    in   DataIn valid
//   SendReady    out  holding buffer empty
//   ParityType   in   00 none, 01 odd, 10 even, 11 none
//   StopBits     in   0: one stop bit, 1: two stop bits
//   MsbFirst     in   0: LSB first, 1: MSB first
//   BreakReq     in   request continuous break (line held low)
//   DataOut      out  registered serial line, idle high
//   ActiveFlag   out  frame or break on the line
//   DoneFlag     out  pulse during the final stop-bit cycle
//   o_dbg_state  out  current FSM state (debug visibility)
// -----------------------------------------------------------------------------
module tx_serializer #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  BaudOut,
    input  logic                  ResetN,
    input  logic [DATA_WIDTH-1:0] DataIn,
    input  logic                  SendValid,
    output logic                  SendReady,
    input  logic [1:0]            ParityType,
    input  logic                  StopBits,
    input  logic                  MsbFirst,
    input  logic                  BreakReq,
    output logic                  DataOut,
    output logic                  ActiveFlag,
    output logic                  DoneFlag,
    output logic [2:0]            o_dbg_state
);

    localparam int            CW       = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_BREAK  = 3'd5
    } state_t;

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_buf;
    logic                  r_buf_full;
    logic [DATA_WIDTH-1:0] r_frame_data;
    logic [1:0]            r_par_type;
    logic                  r_stop2;
    logic                  r_msb;
    logic [CW-1:0]         r_bit_cnt;
    logic                  r_stop_cnt;
    logic                  r_data_out;
    logic                  r_active;
    logic                  r_done;

    state_t                w_state_nxt;
    logic [CW-1:0]         w_bit_cnt_nxt;
    logic                  w_stop_cnt_nxt;
    logic                  w_load;
    logic                  w_accept;
    logic                  w_last_stop;
    logic                  w_par_en;
    logic                  w_par_bit;
    logic [CW-1:0]         w_bit_idx;
    logic                  w_data_nxt;
    logic                  w_done_nxt;

    assign w_accept    = SendValid & ~r_buf_full;
    assign w_par_en    = (r_par_type == 2'b01) || (r_par_type == 2'b10);
    // Odd parity: make the total number of ones odd; even parity: make it even.
    assign w_par_bit   = (r_par_type == 2'b01) ? ~(^r_frame_data) : (^r_frame_data);
    // r_stop_cnt counts 0 or 0,1; the last stop cycle is the one matching r_stop2.
    assign w_last_stop = (r_stop_cnt == r_stop2);

    // Next state and counters.
    always_comb begin
        w_state_nxt    = r_state;
        w_bit_cnt_nxt  = r_bit_cnt;
        w_stop_cnt_nxt = r_stop_cnt;
        w_load         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // A break request takes priority over a buffered word.
                if (BreakReq) begin
                    w_state_nxt = ST_BREAK;
                end else if (r_buf_full) begin
                    w_state_nxt = ST_START;
                    w_load      = 1'b1;
                end
            end
            ST_START: begin
                w_state_nxt   = ST_DATA;
                w_bit_cnt_nxt = '0;
            end
            ST_DATA: begin
                if (r_bit_cnt == LAST_BIT) begin
                    w_state_nxt    = w_par_en ? ST_PARITY : ST_STOP;
                    w_stop_cnt_nxt = 1'b0;
                end else begin
                    w_bit_cnt_nxt = r_bit_cnt + CW'(1);
                end
            end
            ST_PARITY: begin
                w_state_nxt    = ST_STOP;
                w_stop_cnt_nxt = 1'b0;
            end
            ST_STOP: begin
                if (w_last_stop) begin
                    if (BreakReq) begin
                        w_state_nxt = ST_BREAK;
                    end else if (r_buf_full) begin
                        w_state_nxt = ST_START;
                        w_load      = 1'b1;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_stop_cnt_nxt = 1'b1;
                end
            end
            ST_BREAK: begin
                // Always go back through IDLE so the line is high for at least one cycle.
                if (!BreakReq) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // The bit counter holds the index of the data bit on the line, in sending order.
    assign w_bit_idx = r_msb ? (LAST_BIT - w_bit_cnt_nxt) : w_bit_cnt_nxt;

    // Line outputs are decoded from the next state and then registered.
    always_comb begin
        w_data_nxt = 1'b1;
        w_done_nxt = 1'b0;
        case (w_state_nxt)
            ST_START:  w_data_nxt = 1'b0;
            ST_DATA:   w_data_nxt = r_frame_data[w_bit_idx];
            ST_PARITY: w_data_nxt = w_par_bit;
            ST_STOP:   w_done_nxt = (w_stop_cnt_nxt == r_stop2);
            ST_BREAK:  w_data_nxt = 1'b0;
            default:   w_data_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge BaudOut or negedge ResetN) begin
        if (!ResetN) begin
            r_state      <= ST_IDLE;
            r_buf        <= '0;
            r_buf_full   <= 1'b0;
            r_frame_data <= '0;
            r_par_type   <= 2'b00;
            r_stop2      <= 1'b0;
            r_msb        <= 1'b0;
            r_bit_cnt    <= '0;
            r_stop_cnt   <= 1'b0;
            r_data_out   <= 1'b1;
            r_active     <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_bit_cnt  <= w_bit_cnt_nxt;
            r_stop_cnt <= w_stop_cnt_nxt;
            r_data_out <= w_data_nxt;
            r_active   <= (w_state_nxt != ST_IDLE);
            r_done     <= w_done_nxt;
            // w_load needs a full buffer and w_accept needs an empty one.
            // So only one of the two can happen on any edge.
            if (w_load) begin
                r_frame_data <= r_buf;
                r_par_type   <= ParityType;
                r_stop2      <= StopBits;
                r_msb        <= MsbFirst;
                r_buf_full   <= 1'b0;
            end else if (w_accept) begin
                r_buf      <= DataIn;
                r_buf_full <= 1'b1;
            end
        end
    end

    assign SendReady   = ~r_buf_full;
    assign DataOut     = r_data_out;
    assign ActiveFlag  = r_active;
    assign DoneFlag    = r_done;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_tx_serializer.sv
// -----------------------------------------------------------------------------
// tb_tx_serializer
//   Directed bench for tx_serializer. An 8-bit instance is checked every cycle
//   against a frame-level model. The model expands each word into its line
//   cells and replays them. Hand-computed line sequences pin the model.
//   A 5-bit instance covers the narrow-width case.
// -----------------------------------------------------------------------------
module tb_tx_serializer;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    // ---------------- DUT (DATA_WIDTH = 8) ----------------
    logic [7:0] data_in     = '0;
    logic       send_valid  = 1'b0;
    logic       send_ready;
    logic [1:0] parity_type = 2'b00;
    logic       stop_bits   = 1'b0;
    logic       msb_first   = 1'b0;
    logic       break_req   = 1'b0;
    logic       data_out;
    logic       active;
    logic       done;
    logic [2:0] dbg_state;

    tx_serializer #(.DATA_WIDTH(8)) dut (
        .BaudOut     (clk),
        .ResetN      (rst_n),
        .DataIn      (data_in),
        .SendValid   (send_valid),
        .SendReady   (send_ready),
        .ParityType  (parity_type),
        .StopBits    (stop_bits),
        .MsbFirst    (msb_first),
        .BreakReq    (break_req),
        .DataOut     (data_out),
        .ActiveFlag  (active),
        .DoneFlag    (done),
        .o_dbg_state (dbg_state)
    );

    // ---------------- DUT (DATA_WIDTH = 5) ----------------
    logic [4:0] d5_in    = '0;
    logic       d5_valid = 1'b0;
    logic       d5_ready;
    logic       d5_out;
    logic       d5_active;
    logic       d5_done;
    logic [2:0] d5_dbg;

    tx_serializer #(.DATA_WIDTH(5)) dut5 (
        .BaudOut     (clk),
        .ResetN      (rst_n),
        .DataIn      (d5_in),
        .SendValid   (d5_valid),
        .SendReady   (d5_ready),
        .ParityType  (2'b10),
        .StopBits    (1'b0),
        .MsbFirst    (1'b0),
        .BreakReq    (1'b0),
        .DataOut     (d5_out),
        .ActiveFlag  (d5_active),
        .DoneFlag    (d5_done),
        .o_dbg_state (d5_dbg)
    );

    // ---------------- scoreboard counters ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Line cell = {data_out, active, done}.
    localparam logic [2:0] IDLE_C = 3'b100;
    localparam logic [2:0] BRK_C  = 3'b010;

    logic [2:0] m_cur      = IDLE_C;
    logic [2:0] m_q[$];
    logic       m_buf_full = 1'b0;
    logic [7:0] m_buf      = '0;
    logic       m_acc;

    function automatic void push_frame(input logic [7:0] d, input logic [1:0] pt,
                                       input logic st2, input logic msb);
        int   ones;
        logic b;
        ones = 0;
        m_q.push_back(3'b010);
        for (int i = 0; i < 8; i++) begin
            b = msb ? d[7-i] : d[i];
            ones += int'(b);
            m_q.push_back({b, 2'b10});
        end
        if (pt == 2'b01) m_q.push_back({~ones[0], 2'b10});
        else if (pt == 2'b10) m_q.push_back({ones[0], 2'b10});
        if (st2) m_q.push_back(3'b110);
        m_q.push_back(3'b111);
    endfunction

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_q.delete();
                m_cur      = IDLE_C;
                m_buf_full = 1'b0;
            end else begin
                m_acc = send_valid && !m_buf_full;
                if (m_q.size() > 0) begin
                    m_cur = m_q.pop_front();
                end else if (m_cur == BRK_C && !break_req) begin
                    m_cur = IDLE_C;
                end else if (break_req) begin
                    m_cur = BRK_C;
                end else if (m_buf_full) begin
                    push_frame(m_buf, parity_type, stop_bits, msb_first);
                    m_buf_full = 1'b0;
                    m_cur      = m_q.pop_front();
                end else begin
                    m_cur = IDLE_C;
                end
                if (m_acc) begin
                    m_buf      = data_in;
                    m_buf_full = 1'b1;
                end
            end
        end
    end

    // Compare process: outputs are sampled on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            check("model_data_out",   32'(data_out),   32'(m_cur[2]));
            check("model_active",     32'(active),     32'(m_cur[1]));
            check("model_done",       32'(done),       32'(m_cur[0]));
            check("model_send_ready", 32'(send_ready), 32'(!m_buf_full));
        end
    end

    // ---------------- driver tasks (called at a falling edge) ----------------
    task automatic send_word(input logic [7:0] d);
        int guard;
        guard      = 0;
        send_valid = 1'b1;
        data_in    = d;
        while (!send_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: got ready=0 expected ready=1 within 100 cycles");
        end
        @(posedge clk);
        @(negedge clk);
        send_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        while (!(m_q.size() == 0 && m_cur == IDLE_C && !m_buf_full) && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) begin
            n_checks++;
            n_fail++;
            $display("FAIL idle_timeout: got busy expected idle within 200 cycles");
        end
        @(negedge clk);
    endtask

    // Records n line samples. The event evt_kind is applied after sample evt_at.
    task automatic capture(input int n, input int evt_at, input int evt_kind,
                           output logic [31:0] dv, output logic [31:0] dn,
                           output logic [31:0] rdy, output logic [31:0] act);
        dv  = '0;
        dn  = '0;
        rdy = '0;
        act = '0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            dv[i]  = data_out;
            dn[i]  = done;
            rdy[i] = send_ready;
            act[i] = active;
            if (i == evt_at) begin
                case (evt_kind)
                    1: send_valid = 1'b0;
                    2: begin
                        parity_type = 2'b01;
                        msb_first   = 1'b0;
                        stop_bits   = 1'b1;
                        data_in     = 8'hFF;
                    end
                    3: break_req = 1'b0;
                    default: ;
                endcase
            end
        end
    endtask

    // ---------------- directed sequence ----------------
    logic [31:0] cv, cd, cr, ca;

    initial begin
        #1 rst_n = 1'b0;
        #5;
        check("reset_data_out",   32'(data_out),   32'd1);
        check("reset_send_ready", 32'(send_ready), 32'd1);
        check("reset_active",     32'(active),     32'd0);
        check("reset_done",       32'(done),       32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // 0xA5, odd parity, 1 stop, LSB first; accepted on the first edge after reset.
        parity_type = 2'b01; stop_bits = 1'b0; msb_first = 1'b0;
        send_word(8'hA5);
        check("a5_buffer_full", 32'(send_ready), 32'd0);
        capture(11, -1, 0, cv, cd, cr, ca);
        check("a5_line", cv, 32'b11101001010);
        check("a5_done", cd, 32'b10000000000);
        wait_idle();

        // 0x00 then 0xFF back-to-back, no parity, 2 stops.
        parity_type = 2'b00; stop_bits = 1'b1;
        send_word(8'h00);
        send_valid = 1'b1; data_in = 8'hFF;
        capture(22, 1, 1, cv, cd, cr, ca);
        check("b2b_line",  cv, 32'b1111111111_0_11_000000000);
        check("b2b_done",  cd, 32'b1_0000000000_1_0000000000);
        check("b2b_ready", cr, 32'b11111111111_0000000000_1);
        wait_idle();

        // 0x01, MSB first, even parity, 1 stop; settings disturbed mid-frame.
        parity_type = 2'b10; stop_bits = 1'b0; msb_first = 1'b1;
        send_word(8'h01);
        capture(11, 3, 2, cv, cd, cr, ca);
        check("msb_line", cv, 32'b11100000000);
        check("msb_done", cd, 32'b10000000000);
        wait_idle();

        // Break requested while a frame runs and another word is buffered.
        parity_type = 2'b00; stop_bits = 1'b0; msb_first = 1'b0;
        send_word(8'h3C);
        send_word(8'h81);
        break_req = 1'b1;
        capture(24, 12, 3, cv, cd, cr, ca);
        check("brk_line",   cv, 32'b11_000000_1_0_1_00000_1_00_1111_0);
        check("brk_active", ca, 32'b1111111111_0_1111111111111);
        wait_idle();

        // Reset during data bit 3, with a word buffered.
        send_word(8'h5A);
        send_word(8'h33);
        repeat (3) @(negedge clk);
        check("pre_reset_active", 32'(active), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_reset_data_out",   32'(data_out),   32'd1);
        check("mid_reset_send_ready", 32'(send_ready), 32'd1);
        check("mid_reset_active",     32'(active),     32'd0);
        check("mid_reset_done",       32'(done),       32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        send_word(8'h96);
        capture(10, -1, 0, cv, cd, cr, ca);
        check("post_reset_line", cv, 32'b1100101100);
        check("post_reset_done", cd, 32'b1000000000);
        wait_idle();

        // Mixed settings: no parity (11), 2 stops, MSB first, then a queued odd/1-stop frame.
        parity_type = 2'b11; stop_bits = 1'b1; msb_first = 1'b1;
        send_word(8'hC3);
        send_word(8'h7E);
        parity_type = 2'b01; stop_bits = 1'b0; msb_first = 1'b0;
        wait_idle();

        // DATA_WIDTH = 5: 0x1F, even parity, 1 stop.
        d5_in = 5'h1F; d5_valid = 1'b1;
        check("w5_ready", 32'(d5_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        d5_valid = 1'b0;
        cv = '0; cd = '0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            cv[i] = d5_out;
            cd[i] = d5_done;
        end
        check("w5_line", cv, 32'b11111110);
        check("w5_done", cd, 32'b10000000);
        @(negedge clk);
        check("w5_idle_line",   32'(d5_out),    32'd1);
        check("w5_idle_active", 32'(d5_active), 32'd0);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
